// File: rtl/hs_fifo_pkg.sv
// Shared helpers for the HW/SW synchronisation FIFO.
// Optional level flags are enabled by defining HS_FIFO_LEVEL_FLAGS_EN.
package hs_fifo_pkg;

  // Handshake fire indicator width
  localparam int unsigned FIRE_W = 1;

  // Ceiling log2 for pointer sizing, minimum result of 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/hs_sync_fifo_ptr.sv
// Wrapping pointer counter; relies on a power-of-two depth for natural wrap.
module hs_fifo_ptr #(
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_next;

  // Increment; DEPTH-1 wraps to 0 by overflow
  always_comb begin
    ptr_next = AW'(ptr + AW'(1));
  end

  Register #(.W(AW), .HAS_RST(1'b1), .RST_VAL('0)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (ptr_next),
    .q   (ptr)
  );

endmodule

// File: rtl/hs_sync_fifo_register.sv
// Generic enabled register with optional synchronous active-high reset.
module Register #(
  parameter int unsigned W = 1,
  parameter bit HAS_RST = 1'b1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable; reset wins when the instance is resettable
  always_ff @(posedge clk) begin
    if (rst && HAS_RST) q <= RST_VAL;
    else if (en)        q <= d;
  end

endmodule

// File: rtl/hs_sync_fifo.sv
// Synchronous FWFT FIFO with valid/ready on both sides.
// Define HS_FIFO_LEVEL_FLAGS_EN to add almost_full/almost_empty outputs.
module hs_sync_fifo
  import hs_fifo_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
`ifdef HS_FIFO_LEVEL_FLAGS_EN
  ,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
`endif
  ,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [N-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [N-1:0] rd_data,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
`ifdef HS_FIFO_LEVEL_FLAGS_EN
  ,
  output logic         almost_full,
  output logic         almost_empty
`endif
);

  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic [N-1:0]  mem [DEPTH];

  // Status derived from registered count only
  always_comb begin
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    wr_ready = !full && !rst;
    rd_valid = !empty;
    push     = wr_valid && wr_ready;
    pop      = rd_valid && rd_ready && !rst;
  end

  // Occupancy update: +1 push only, -1 pop only, hold otherwise
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = (AW+1)'(count + (AW+1)'(1));
    else if (pop && !push) count_next = (AW+1)'(count - (AW+1)'(1));
  end

  Register #(.W(AW+1), .HAS_RST(1'b1), .RST_VAL('0)) u_count (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (count_next),
    .q   (count)
  );

  hs_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (push),
    .ptr (wr_ptr)
  );

  hs_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop),
    .ptr (rd_ptr)
  );

  // Storage words are not cleared by reset; only the slot under wr_ptr loads
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    logic slot_en;
    assign slot_en = push && (wr_ptr == AW'(i));
    Register #(.W(N), .HAS_RST(1'b0), .RST_VAL('0)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (slot_en),
      .d   (wr_data),
      .q   (mem[i])
    );
  end

  // Head-of-queue select, no write bypass
  always_comb begin
    rd_data = mem[rd_ptr];
  end

`ifdef HS_FIFO_LEVEL_FLAGS_EN
  logic af_next;
  logic ae_next;

  // Level flags track the count that will be registered this edge
  always_comb begin
    af_next = (32'(count_next) >= AF_LEVEL);
    ae_next = (32'(count_next) <= AE_LEVEL);
  end

  Register #(.W(1), .HAS_RST(1'b1), .RST_VAL(1'b0)) u_af (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (af_next),
    .q   (almost_full)
  );

  Register #(.W(1), .HAS_RST(1'b1), .RST_VAL(1'b1)) u_ae (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (ae_next),
    .q   (almost_empty)
  );
`else
  // Level flags absent in this build
`endif

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Directed self-checking bench for hs_sync_fifo (N=8, DEPTH=4).
module tb_hs_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef HS_FIFO_LEVEL_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int checks;
  int errors;

  hs_sync_fifo #(.N(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .full         (full),
    .empty        (empty)
`ifdef HS_FIFO_LEVEL_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
`ifdef HS_FIFO_LEVEL_FLAGS_EN
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
    rst = 1'b0;
    #1;
    chk("rel_wr_ready", 32'(wr_ready), 32'd1);

    // Fill then drain
    wr_valid = 1'b1;
    wr_data = 8'h11; tick();
    chk("fill_count1", 32'(count), 32'd1);
    chk("fill_head", 32'(rd_data), 32'h11);
    chk("fill_rd_valid", 32'(rd_valid), 32'd1);
    wr_data = 8'h22; tick();
    wr_data = 8'h33; tick();
`ifdef HS_FIFO_LEVEL_FLAGS_EN
    chk("af_at3", 32'(almost_full), 32'd1);
    chk("ae_at3", 32'(almost_empty), 32'd0);
`endif
    wr_data = 8'h44; tick();
    wr_valid = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    chk("fill_count4", 32'(count), 32'd4);
    rd_ready = 1'b1;
    chk("drain0", 32'(rd_data), 32'h11); tick();
    chk("drain1", 32'(rd_data), 32'h22); tick();
    chk("drain2", 32'(rd_data), 32'h33); tick();
    chk("drain3", 32'(rd_data), 32'h44); tick();
    rd_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // Continuous streaming across pointer wrap
    wr_valid = 1'b1;
    wr_data = 8'hA0; tick();
    chk("wrap_first_count", 32'(count), 32'd1);
    rd_ready = 1'b1;
    for (int k = 1; k < 10; k++) begin
      wr_data = 8'hA0 + 8'(k);
      chk("wrap_data", 32'(rd_data), 32'hA0 + 32'(k) - 32'd1);
      tick();
      chk("wrap_count", 32'(count), 32'd1);
    end
    wr_valid = 1'b0;
    chk("wrap_last", 32'(rd_data), 32'hA9);
    tick();
    rd_ready = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);

    // Full with simultaneous pop: pop only, push next cycle
    wr_valid = 1'b1;
    wr_data = 8'h51; tick();
    wr_data = 8'h52; tick();
    wr_data = 8'h53; tick();
    wr_data = 8'h54; tick();
    chk("fp_count4", 32'(count), 32'd4);
    wr_data = 8'h55;
    rd_ready = 1'b1;
    chk("fp_wr_ready", 32'(wr_ready), 32'd0);
    chk("fp_head", 32'(rd_data), 32'h51);
    tick();
    chk("fp_count3", 32'(count), 32'd3);
    rd_ready = 1'b0;
    chk("fp_wr_ready_next", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("fp_count_refill", 32'(count), 32'd4);
    rd_ready = 1'b1;
    chk("fp_d0", 32'(rd_data), 32'h52); tick();
    chk("fp_d1", 32'(rd_data), 32'h53); tick();
    chk("fp_d2", 32'(rd_data), 32'h54); tick();
    chk("fp_d3", 32'(rd_data), 32'h55); tick();
    rd_ready = 1'b0;
    chk("fp_empty", 32'(empty), 32'd1);

    // Empty with simultaneous push: push only
    wr_valid = 1'b1;
    wr_data = 8'h66;
    rd_ready = 1'b1;
    chk("ep_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("ep_count", 32'(count), 32'd1);
    chk("ep_rd_valid_next", 32'(rd_valid), 32'd1);
    chk("ep_data", 32'(rd_data), 32'h66);
`ifdef HS_FIFO_LEVEL_FLAGS_EN
    chk("ae_at1", 32'(almost_empty), 32'd1);
    chk("af_at1", 32'(almost_full), 32'd0);
`endif
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("ep_drained", 32'(count), 32'd0);

    // Mid-stream reset at count 3
    wr_valid = 1'b1;
    wr_data = 8'h71; tick();
    wr_data = 8'h72; tick();
    wr_data = 8'h73; tick();
    wr_valid = 1'b0;
    chk("mr_count3", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_rd_valid", 32'(rd_valid), 32'd0);
    chk("mr_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'h80; tick();
    wr_valid = 1'b0;
    chk("mr_repush_count", 32'(count), 32'd1);
    chk("mr_repush_data", 32'(rd_data), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
